tss_command_scheduler: RTL
==========================

Name: tss_command_scheduler

Overview:
Consumer end of the TSS command bus driven by the Wishbone-facing register slave.
- Detects each new command word and decodes opcode, execution timestamp and sequence parameters.
- Holds timed commands until the local timer reaches the execution time, then emits one-cycle start/stop/continue pulses and a session run level to the TSS TX controller.
- Enforces a legal session state sequence and flags rejected commands.

Parameters:
TS_W, TIMESTAMP_WIDTH (tss_pkg), timer and timestamp width
FIELD_W, 32, width of each sequence parameter field

Ports:
clk  in  1  system clock
arst  in  1  asynchronous reset, active-high
timer_valid_i  in  1  timer valid; low acts as synchronous clear
timer_i  in  TS_W  free-running local time
command_i  in  COMMAND_WIDTH  {params(6*FIELD_W), exec_time(TS_W), opcode(8)}
params_o  out  6*FIELD_W  tss_params_t latched at START execution
start_o  out  1  one-cycle pulse, START executed
stop_o  out  1  one-cycle pulse, STOP executed
continue_o  out  1  one-cycle pulse, CONTINUE executed
abort_o  out  1  one-cycle pulse, ABORT executed
run_o  out  1  session running level
armed_o  out  1  a timed command is pending
reject_o  out  1  one-cycle pulse, command refused

Behaviour:
- Clock and reset: one clock `clk`. Reset `arst` is asynchronous, active-high. While `timer_valid_i` is low, the block is held in the reset state.
- Reset state: all outputs 0; FSM in IDLE; session state STOPPED; prev_op = 0.
- Command detection:
  - prev_op is a register holding the previous cycle's opcode.
  - A command is captured when opcode != 0 and prev_op == 0.
  - Held command words are never re-captured, even though exec_time changes while held.
- Opcodes: 0x01 START, 0x02 STOP, 0x04 CONTINUE, 0x08 ABORT. Any other nonzero opcode gives reject_o and is otherwise ignored.
- Scheduling FSM (IDLE, ARMED):
  - IDLE + legal timed command: latch opcode, exec_time and params; go to ARMED; armed_o = 1 from the next cycle.
  - ARMED, due = ~(timer_i - exec_time)[TS_W-1] (wrap-safe difference, modulo 2^TS_W): at that edge assert the matching pulse for exactly one cycle, update session state, return to IDLE.
  - A due command fires one cycle after capture at the earliest.
- Session legality, checked at capture time:
  - START is legal only from STOPPED. It loads params_o at execution; run_o goes to 1.
  - STOP is legal only from RUNNING. It moves the session to PAUSED; run_o goes to 0.
  - CONTINUE is legal only from PAUSED. It moves the session to RUNNING; run_o goes to 1.
  - An illegal command gives reject_o and causes no state change.
- ABORT:
  - Accepted in any state; not timed.
  - abort_o pulses one cycle after capture.
  - Clears the pending command, armed_o and run_o; session goes to STOPPED; params_o is retained.
- Non-ABORT capture while ARMED: reject_o; the pending command is unchanged.
- Simultaneous events: if the pending command fires on the same edge a new command is captured, the fire happens first and the new command is checked against the updated session state.
- timer_valid_i dropping mid-operation: pending command discarded and all state cleared with no pulses.
- Pulses are registered and mutually exclusive per cycle. reject_o may coincide with a fire pulse.

Optional Feature:
TSS_LATE_REJECT_EN
- Defined: a timed command whose exec_time is already due at capture gives reject_o and is not armed.
- Undefined: a late command is armed and fires on the next cycle.

Decomposition:
- tss_pkg additions:
  - opcode localparams OP_START, OP_STOP, OP_CONTINUE, OP_ABORT (moved out of the slave and shared by both ends)
  - tss_params_t packed struct (slice, frame, batch, sequence, batch_interval, last_frame)
  - tss_command_t packed struct {params, exec_time, opcode}
  - sched_state_e, session_state_e enums
- Sub-module tss_time_cmp: registered-free wrap-safe "a >= b" on TS_W bits. Reused by the TX controller.

Test Plan:
- Reset then START, exec_time = timer + 10, params all 0x5, held 3 cycles -> single capture; armed_o = 1; start_o one pulse exactly 10 cycles after capture edge (±0, check); params_o = 0x5 fields; run_o = 1.
- START executed, then STOP at +5, then CONTINUE at +5 -> stop_o then continue_o pulses; run_o 1 -> 0 -> 1.
- CONTINUE from STOPPED, then START while ARMED -> two reject_o pulses, no state change.
- ARMED START at +100, ABORT at +3 -> abort_o pulse one cycle after capture; start_o never asserts; armed_o = 0; run_o = 0.
- timer near 2^TS_W-4, exec_time = 2 (wrapped) -> fires 6 cycles after capture, not immediately.
- Late command exec_time = timer - 5: without macro it fires next cycle; with TSS_LATE_REJECT_EN it gives reject_o. Also: opcode 0x10 -> reject_o; timer_valid_i low while ARMED -> all outputs 0.

Source files
------------

// File: rtl/tss_pkg.sv
// -----------------------------------------------------------------------------
// tss_pkg
// Shared definitions for the TSS command path: the register slave (producer)
// and the command scheduler / TX controller (consumers).
//   - TIMESTAMP_WIDTH / FIELD_WIDTH : timer and sequence-parameter widths
//   - OP_* opcodes                  : one-hot command opcodes on the bus
//   - tss_params_t / tss_command_t  : layout of the command word
//   - sched_state_e / session_state_e: scheduler FSM and session states
// -----------------------------------------------------------------------------
package tss_pkg;

    localparam int TIMESTAMP_WIDTH = 32;
    localparam int FIELD_WIDTH     = 32;
    localparam int OPCODE_WIDTH    = 8;

    localparam logic [OPCODE_WIDTH-1:0] OP_START    = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_STOP     = 8'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_CONTINUE = 8'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_ABORT    = 8'h08;

    typedef struct packed {
        logic [FIELD_WIDTH-1:0] slice;
        logic [FIELD_WIDTH-1:0] frame;
        logic [FIELD_WIDTH-1:0] batch;
        logic [FIELD_WIDTH-1:0] sequence_id;
        logic [FIELD_WIDTH-1:0] batch_interval;
        logic [FIELD_WIDTH-1:0] last_frame;
    } tss_params_t;

    typedef struct packed {
        tss_params_t                  params;
        logic [TIMESTAMP_WIDTH-1:0]   exec_time;
        logic [OPCODE_WIDTH-1:0]      opcode;
    } tss_command_t;

    localparam int COMMAND_WIDTH = $bits(tss_command_t);

    typedef enum logic {
        SCHED_IDLE,
        SCHED_ARMED
    } sched_state_e;

    typedef enum logic [1:0] {
        SESS_STOPPED,
        SESS_RUNNING,
        SESS_PAUSED
    } session_state_e;

    // Timed opcodes are the ones that wait for exec_time; ABORT is immediate.
    function automatic logic is_timed_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_START) || (op == OP_STOP) || (op == OP_CONTINUE);
    endfunction

    // Legal session transitions for timed commands.
    function automatic logic op_legal(input logic [OPCODE_WIDTH-1:0] op,
                                      input session_state_e          sess);
        logic ok;
        ok = 1'b0;
        if (op == OP_START)    ok = (sess == SESS_STOPPED);
        if (op == OP_STOP)     ok = (sess == SESS_RUNNING);
        if (op == OP_CONTINUE) ok = (sess == SESS_PAUSED);
        return ok;
    endfunction

endpackage

// File: rtl/tss_time_cmp.sv
// -----------------------------------------------------------------------------
// tss_time_cmp
// Purely combinational wrap-safe "a >= b" on free-running W-bit timestamps.
// The difference is taken modulo 2^W and its sign bit decides, so the result
// is correct as long as the two values are within 2^(W-1) of each other.
// Ports:
//   a_i  : current time
//   b_i  : reference (e.g. execution) time
//   ge_o : a_i is at or past b_i
// -----------------------------------------------------------------------------
module tss_time_cmp #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         ge_o
);

    logic [W-1:0] diff;

    assign diff = a_i - b_i;
    assign ge_o = ~diff[W-1];

endmodule

// File: rtl/tss_command_scheduler.sv
// -----------------------------------------------------------------------------
// tss_command_scheduler
// Consumer end of the TSS command bus. Captures each new command word
// (rising edge of a nonzero opcode), checks it against the session state,
// holds timed commands until the local timer reaches exec_time and then
// issues one-cycle start/stop/continue pulses plus a session run level.
//
// Build option:
//   TSS_LATE_REJECT_EN - when defined, a timed command whose exec_time is
//                        already due at capture is refused (reject_o) rather
//                        than armed to fire on the next cycle.
//
// Ports:
//   clk, arst       : clock, asynchronous active-high reset
//   timer_valid_i   : low holds the whole block in its reset state
//   timer_i         : free-running local time
//   command_i       : {params, exec_time, opcode}
//   params_o        : sequence parameters latched when START executes
//   start_o/stop_o/continue_o/abort_o : one-cycle execution pulses
//   run_o           : session running level
//   armed_o         : a timed command is pending
//   reject_o        : one-cycle pulse, command refused
// -----------------------------------------------------------------------------
module tss_command_scheduler
    import tss_pkg::*;
#(
    parameter int TS_W    = TIMESTAMP_WIDTH,
    parameter int FIELD_W = 32
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          timer_valid_i,
    input  logic [TS_W-1:0]               timer_i,
    input  logic [6*FIELD_W+TS_W+8-1:0]   command_i,
    output logic [6*FIELD_W-1:0]          params_o,
    output logic                          start_o,
    output logic                          stop_o,
    output logic                          continue_o,
    output logic                          abort_o,
    output logic                          run_o,
    output logic                          armed_o,
    output logic                          reject_o
);

    localparam int PARAM_W = 6 * FIELD_W;
    localparam int CMD_W   = PARAM_W + TS_W + 8;

    // Command word fields
    logic [7:0]         cmd_op;
    logic [TS_W-1:0]    cmd_exec;
    logic [PARAM_W-1:0] cmd_params;

    assign cmd_op     = command_i[7:0];
    assign cmd_exec   = command_i[TS_W+7:8];
    assign cmd_params = command_i[CMD_W-1:TS_W+8];

    // State
    sched_state_e       state_q, state_d;
    session_state_e     session_q, session_d;
    logic [7:0]         prev_op_q, prev_op_d;
    logic [7:0]         op_q, op_d;
    logic [TS_W-1:0]    exec_q, exec_d;
    logic [PARAM_W-1:0] pend_params_q, pend_params_d;
    logic [PARAM_W-1:0] params_q, params_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;
    logic               continue_q, continue_d;
    logic               abort_q, abort_d;
    logic               reject_q, reject_d;

    logic               due_pending;
    logic               late_reject;
    logic               fire;
    logic               capture;

    tss_time_cmp #(.W(TS_W)) u_due_cmp (
        .a_i  (timer_i),
        .b_i  (exec_q),
        .ge_o (due_pending)
    );

`ifdef TSS_LATE_REJECT_EN
    logic late_due;

    // Compares the incoming command's exec_time, not the pending one.
    tss_time_cmp #(.W(TS_W)) u_late_cmp (
        .a_i  (timer_i),
        .b_i  (cmd_exec),
        .ge_o (late_due)
    );

    assign late_reject = late_due;
`else
    assign late_reject = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        session_d     = session_q;
        prev_op_d     = cmd_op;
        op_d          = op_q;
        exec_d        = exec_q;
        pend_params_d = pend_params_q;
        params_d      = params_q;
        start_d       = 1'b0;
        stop_d        = 1'b0;
        continue_d    = 1'b0;
        abort_d       = 1'b0;
        reject_d      = 1'b0;

        fire    = (state_q == SCHED_ARMED) && due_pending;
        capture = (cmd_op != 8'h00) && (prev_op_q == 8'h00);

        // Fire is resolved first so a command captured on the same edge is
        // judged against the post-fire scheduler and session state.
        if (fire) begin
            state_d = SCHED_IDLE;
            case (op_q)
                OP_START: begin
                    start_d   = 1'b1;
                    params_d  = pend_params_q;
                    session_d = SESS_RUNNING;
                end
                OP_STOP: begin
                    stop_d    = 1'b1;
                    session_d = SESS_PAUSED;
                end
                OP_CONTINUE: begin
                    continue_d = 1'b1;
                    session_d  = SESS_RUNNING;
                end
                default: ;
            endcase
        end

        if (capture) begin
            if (cmd_op == OP_ABORT) begin
                // ABORT wins over a coinciding fire so pulses stay exclusive;
                // the aborted command's effects (incl. params) are dropped.
                start_d    = 1'b0;
                stop_d     = 1'b0;
                continue_d = 1'b0;
                params_d   = params_q;
                abort_d    = 1'b1;
                state_d    = SCHED_IDLE;
                session_d  = SESS_STOPPED;
            end else if (is_timed_op(cmd_op)) begin
                if ((state_d == SCHED_IDLE) && op_legal(cmd_op, session_d)
                    && !late_reject) begin
                    state_d       = SCHED_ARMED;
                    op_d          = cmd_op;
                    exec_d        = cmd_exec;
                    pend_params_d = cmd_params;
                end else begin
                    reject_d = 1'b1;
                end
            end else begin
                reject_d = 1'b1;
            end
        end

        // Timer not valid: synchronous clear back to the reset state.
        if (!timer_valid_i) begin
            state_d       = SCHED_IDLE;
            session_d     = SESS_STOPPED;
            prev_op_d     = '0;
            op_d          = '0;
            exec_d        = '0;
            pend_params_d = '0;
            params_d      = '0;
            start_d       = 1'b0;
            stop_d        = 1'b0;
            continue_d    = 1'b0;
            abort_d       = 1'b0;
            reject_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= SCHED_IDLE;
            session_q     <= SESS_STOPPED;
            prev_op_q     <= '0;
            op_q          <= '0;
            exec_q        <= '0;
            pend_params_q <= '0;
            params_q      <= '0;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
            continue_q    <= 1'b0;
            abort_q       <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            session_q     <= session_d;
            prev_op_q     <= prev_op_d;
            op_q          <= op_d;
            exec_q        <= exec_d;
            pend_params_q <= pend_params_d;
            params_q      <= params_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
            continue_q    <= continue_d;
            abort_q       <= abort_d;
            reject_q      <= reject_d;
        end
    end

    assign params_o   = params_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign continue_o = continue_q;
    assign abort_o    = abort_q;
    assign reject_o   = reject_q;
    assign run_o      = (session_q == SESS_RUNNING);
    assign armed_o    = (state_q == SCHED_ARMED);

endmodule
